manchester_tx_ctrl: RTL and testbench

Frame controller that sequences the team's byte-wide Manchester encoder onto a single serial line. It accepts bytes over a valid/ready stream, inserts a fixed preamble, presents each byte to the encoder, captures the 16-bit encoded word and shifts it out one half-bit at a time at a programmable rate, then closes the frame with a trailer. The encoder is external and is wired through the enc_* ports; this block owns all sequencing, pacing and flow control around it.

---
 rtl/manchester_tx_ctrl_pkg.sv | 18 +
 rtl/mtx_baud_tick.sv | 29 ++
 rtl/manchester_tx_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_manchester_tx_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/manchester_tx_ctrl_pkg.sv
// Shared types and constants for the Manchester frame transmitter.
package manchester_tx_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GUARD,
    ST_PRE,
    ST_DATA,
    ST_TRAIL
  } state_e;

  localparam logic [7:0]  PRE_BYTE           = 8'h55;
  localparam int unsigned TRAIL_HALF_BITS    = 2;
  localparam int unsigned HALF_BITS_PER_BYTE = 16;
  localparam int unsigned HB_W               = 4;
  localparam int unsigned PRE_CNT_W          = 4;

endpackage

// File: rtl/mtx_baud_tick.sv
// Half-bit pacing: reloadable down-counter, one tick every max(div,1)+1 enabled cycles.
module mtx_baud_tick #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick_c,
  output logic [DIV_W-1:0] cnt
);

  logic [DIV_W-1:0] div_eff_c;

  assign div_eff_c = (div == '0) ? DIV_W'(1) : div;
  assign tick_c    = en && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= div_eff_c;
    end else if (en) begin
      cnt <= tick_c ? div_eff_c : cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/manchester_tx_ctrl.sv
// Frame sequencer around an external byte-wide Manchester encoder:
// guard half-bit, preamble, payload words MSB-first, two-half-bit trailer.
module manchester_tx_ctrl
  import manchester_tx_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W     = 8,
  parameter int unsigned PRE_BYTES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_mode,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       enc_data,
  output logic             enc_mode,
  input  logic [15:0]      enc_word,
  output logic             line_out,
  output logic             line_oe,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_err
);

  state_e                 state;
  logic [DIV_W-1:0]       div_q;
  logic [15:0]            sreg;
  logic [HB_W-1:0]        hb;
  logic [PRE_CNT_W-1:0]   pre_cnt;
  logic [7:0]             hold_data;
  logic                   hold_full;
  logic                   hold_last;
  logic                   cur_last;
  logic                   last_seen;

  logic                   tick_c;
  logic [DIV_W-1:0]       cnt;
  logic [DIV_W-1:0]       div_sel_c;
  logic                   accept_c;
  logic                   start_c;
  logic                   div_one_c;
  logic                   close_nxt_c;

  assign accept_c  = in_valid && in_ready;
  assign start_c   = accept_c && (state == ST_IDLE);
  assign div_sel_c = (state == ST_IDLE) ? cfg_div : div_q;
  assign div_one_c = (div_q <= DIV_W'(1));
  // Next cycle falls in the last two cycles before a byte boundary.
  assign close_nxt_c = tick_c ? ((hb == HB_W'(1)) && div_one_c)
                              : ((hb == '0) && (cnt <= DIV_W'(2)));

  mtx_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr    (start_c),
    .en     (state != ST_IDLE),
    .div    (div_sel_c),
    .tick_c (tick_c),
    .cnt    (cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      line_out   <= 1'b0;
      line_oe    <= 1'b0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      enc_data   <= PRE_BYTE;
      enc_mode   <= 1'b0;
      div_q      <= '0;
      sreg       <= '0;
      hb         <= '0;
      pre_cnt    <= '0;
      hold_data  <= '0;
      hold_full  <= 1'b0;
      hold_last  <= 1'b0;
      cur_last   <= 1'b0;
      last_seen  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      // Encoder input trails the queue head by one cycle; boundaries are far enough away.
      enc_data <= ((state == ST_IDLE) || (state == ST_GUARD) ||
                   ((state == ST_PRE) && (pre_cnt > PRE_CNT_W'(1)))) ? PRE_BYTE : hold_data;
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (start_c) begin
            in_ready  <= 1'b0;
            hold_data <= in_data;
            hold_full <= 1'b1;
            hold_last <= in_last;
            last_seen <= in_last;
            div_q     <= cfg_div;
            enc_mode  <= cfg_mode;
            busy      <= 1'b1;
            line_oe   <= 1'b1;
            line_out  <= 1'b0;
            pre_cnt   <= PRE_CNT_W'(PRE_BYTES);
            state     <= ST_GUARD;
          end
        end
        ST_GUARD: begin
          in_ready <= 1'b0;
          if (tick_c) begin
            line_out <= enc_word[15];
            sreg     <= {enc_word[14:0], 1'b0};
            hb       <= HB_W'(HALF_BITS_PER_BYTE - 1);
            state    <= ST_PRE;
          end
        end
        ST_PRE: begin
          in_ready <= 1'b0;
          if (tick_c) begin
            if (hb == '0) begin
              line_out <= enc_word[15];
              sreg     <= {enc_word[14:0], 1'b0};
              hb       <= HB_W'(HALF_BITS_PER_BYTE - 1);
              pre_cnt  <= pre_cnt - PRE_CNT_W'(1);
              if (pre_cnt == PRE_CNT_W'(1)) begin
                hold_full <= 1'b0;
                cur_last  <= hold_last;
                in_ready  <= !last_seen;
                state     <= ST_DATA;
              end
            end else begin
              line_out <= sreg[15];
              sreg     <= {sreg[14:0], 1'b0};
              hb       <= hb - HB_W'(1);
            end
          end
        end
        ST_DATA: begin
          in_ready <= !hold_full && !last_seen && !close_nxt_c;
          if (accept_c) begin
            hold_data <= in_data;
            hold_full <= 1'b1;
            hold_last <= in_last;
            last_seen <= in_last;
            in_ready  <= 1'b0;
          end
          if (tick_c) begin
            if (hb == '0) begin
              if (hold_full) begin
                line_out  <= enc_word[15];
                sreg      <= {enc_word[14:0], 1'b0};
                hb        <= HB_W'(HALF_BITS_PER_BYTE - 1);
                hold_full <= 1'b0;
                cur_last  <= hold_last;
                in_ready  <= !last_seen;
              end else begin
                line_out  <= 1'b0;
                hb        <= HB_W'(TRAIL_HALF_BITS - 1);
                in_ready  <= 1'b0;
                frame_err <= !cur_last;
                state     <= ST_TRAIL;
              end
            end else begin
              line_out <= sreg[15];
              sreg     <= {sreg[14:0], 1'b0};
              hb       <= hb - HB_W'(1);
            end
          end
        end
        ST_TRAIL: begin
          in_ready <= 1'b0;
          if (tick_c) begin
            if (hb == '0) begin
              line_oe    <= 1'b0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              hb <= hb - HB_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_manchester_tx_ctrl.sv
// Randomized bench for manchester_tx_ctrl against a half-bit stream model.
module tb_manchester_tx_ctrl;

  localparam int unsigned DIV_W     = 8;
  localparam int unsigned PRE_BYTES = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_mode;
  logic [7:0]       in_data;
  logic             in_last;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       enc_data;
  logic             enc_mode;
  logic [15:0]      enc_word;
  logic             line_out;
  logic             line_oe;
  logic             busy;
  logic             frame_done;
  logic             frame_err;

  int               n_tests;
  int               n_fail;
  logic [7:0]       frame_bytes [4];

  manchester_tx_ctrl #(.DIV_W(DIV_W), .PRE_BYTES(PRE_BYTES)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_div    (cfg_div),
    .cfg_mode   (cfg_mode),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .enc_data   (enc_data),
    .enc_mode   (enc_mode),
    .enc_word   (enc_word),
    .line_out   (line_out),
    .line_oe    (line_oe),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // External encoder: each bit becomes a pair, bit 7 lands in [15:14].
  function automatic logic [15:0] enc_model(input logic [7:0] b, input logic m);
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) w[2*i +: 2] = (b[i] ^ m) ? 2'b10 : 2'b01;
    return w;
  endfunction

  assign enc_word = enc_model(enc_data, enc_mode);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  function automatic int bnd(input int d, input int j);
    return d * (1 + 16 * j);
  endfunction

  // Send frame_bytes[0..n-1] streaming; underrun leaves the single byte without last.
  task automatic run_frame(input int n, input logic [7:0] div, input logic mode,
                           input bit underrun, input int chg_at);
    int         d;
    int         len;
    int         bi;
    int         wait_n;
    bit         acc;
    bit         hbits[$];
    logic [7:0] b;
    logic       lo_e;
    logic       oe_e;
    logic       rdy_e;
    logic [5:0] got;
    logic [5:0] want;

    d = (div == 8'd0) ? 2 : int'(div) + 1;
    hbits = {};
    hbits.push_back(1'b0);
    for (int k = 0; k < int'(PRE_BYTES) + n; k++) begin
      b = (k < int'(PRE_BYTES)) ? 8'h55 : frame_bytes[k - int'(PRE_BYTES)];
      for (int i = 7; i >= 0; i--) begin
        hbits.push_back(b[i] ^ mode);
        hbits.push_back(~(b[i] ^ mode));
      end
    end
    hbits.push_back(1'b0);
    hbits.push_back(1'b0);
    len = d * hbits.size();

    cfg_div  = div;
    cfg_mode = mode;
    in_data  = frame_bytes[0];
    in_last  = (n == 1) && !underrun;
    in_valid = 1'b1;
    wait_n   = 0;
    while (!in_ready && wait_n < 50) begin
      @(posedge clk); #1;
      wait_n++;
    end
    check_eq("start_rdy", 32'(in_ready), 32'd1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bi = 1;
    if (bi < n) begin
      in_data = frame_bytes[bi];
      in_last = (bi == n - 1);
      bi++;
    end else begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end

    for (int r = 1; r <= len + 1; r++) begin
      oe_e = (r <= len);
      lo_e = (r <= len) ? hbits[(r - 1) / d] : 1'b0;
      rdy_e = 1'b0;
      if (underrun)
        rdy_e = (r >= bnd(d, PRE_BYTES) + 1) && (r <= bnd(d, PRE_BYTES + 1) - 2);
      else
        for (int i = 1; i < n; i++)
          if (r == bnd(d, PRE_BYTES + i - 1) + 1) rdy_e = 1'b1;
      want = {oe_e, oe_e, lo_e, rdy_e, 1'(r == len + 1),
              1'(underrun && (r == bnd(d, PRE_BYTES + 1) + 1))};
      got  = {line_oe, busy, line_out, in_ready, frame_done, frame_err};
      check_eq($sformatf("cyc%0d", r), 32'(got), 32'(want));
      if (r == 1) check_eq("enc_mode", 32'(enc_mode), 32'(mode));
      if (r == chg_at) cfg_div = 8'd5;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        if (bi < n) begin
          in_data = frame_bytes[bi];
          in_last = (bi == n - 1);
          bi++;
        end else begin
          in_valid = 1'b0;
          in_last  = 1'b0;
        end
      end
    end
    check_eq("idle_rdy", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    logic [7:0] dv;
    logic       md;

    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    cfg_div  = 8'd1;
    cfg_mode = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    in_valid = 1'b0;
    #2;
    check_eq("reset", 32'({line_out, line_oe, in_ready, busy, frame_done, frame_err, enc_mode, enc_data}),
             32'({7'b0, 8'h55}));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rdy_after_rst", 32'(in_ready), 32'd1);

    frame_bytes[0] = 8'hA5;
    run_frame(1, 8'd1, 1'b0, 1'b0, 0);

    frame_bytes[0] = 8'h3C; frame_bytes[1] = 8'hF0; frame_bytes[2] = 8'h81;
    run_frame(3, 8'd1, 1'b0, 1'b0, 0);

    frame_bytes[0] = 8'h11;
    run_frame(1, 8'd1, 1'b0, 1'b1, 0);

    // Reset 30 cycles into a frame.
    cfg_div  = 8'd1;
    cfg_mode = 1'b0;
    in_data  = 8'hC3;
    in_last  = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    check_eq("oe_before_rst", 32'({line_oe, busy}), 32'd3);
    rst = 1'b1;
    #1;
    check_eq("rst_async", 32'({line_oe, busy, frame_done, in_ready}), 32'd0);
    @(posedge clk); #1;
    check_eq("rst_hold", 32'({line_oe, in_ready, frame_done}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rdy_after_rel", 32'(in_ready), 32'd1);
    frame_bytes[0] = 8'h5A;
    run_frame(1, 8'd1, 1'b0, 1'b0, 0);

    frame_bytes[0] = 8'hE7; frame_bytes[1] = 8'h18;
    run_frame(2, 8'd1, 1'b0, 1'b0, 5);
    frame_bytes[0] = 8'h96;
    run_frame(1, 8'd5, 1'b0, 1'b0, 0);

    frame_bytes[0] = 8'hA5;
    run_frame(1, 8'd0, 1'b0, 1'b0, 0);

    frame_bytes[0] = 8'h0F; frame_bytes[1] = 8'hC2;
    run_frame(2, 8'd2, 1'b1, 1'b0, 0);

    for (int t = 0; t < 6; t++) begin
      n  = int'($urandom_range(4, 1));
      dv = 8'($urandom_range(3, 0));
      md = 1'($urandom_range(1, 0));
      for (int i = 0; i < 4; i++) frame_bytes[i] = 8'($urandom);
      run_frame(n, dv, md, 1'b0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
